mux_sched_rr3: RTL and testbench
================================

// Module: mux_sched_rr3
// PURPOSE
//  Round-robin burst scheduler for the shared 4-bit 3:1 symbol mux in the RS(15,11) decoder.
//  Three symbol sources request the mux; the winner holds it for one codeword burst of BURST_LEN symbols.
//  Sources are the received-word buffer, syndrome/correction and error-magnitude.
//  Drives mux CONTROL, per-source grants/acks and a downstream valid/done handshake.
// PARAMETERS
//  BURST_LEN  15  symbols per granted burst (1..15; CNT is 4 bits)
// PORTS
//  CLK        in   1  system clock, rising edge
//  RESET      in   1  asynchronous, active-high reset
//  REQ        in   3  per-source request; bit i = source on mux input IN(i+1)
//  READY      in   1  downstream accepts current symbol this cycle
//  CONTROL    out  2  mux select: 0=IN1, 1=IN2, 2=IN3 (never 3)
//  GNT        out  3  one-hot grant, registered
//  SYM_ACK    out  3  GNT & {3{READY}} while XFER (comb): source advances its symbol
//  VALID_OUT  out  1  mux output carries a valid symbol
//  SYM_CNT    out  4  index of current symbol within burst (0..BURST_LEN-1)
//  DONE       out  1  1-cycle pulse, cycle after last symbol accepted
//  ABORT      out  1  1-cycle pulse, burst cut short by REQ drop
// BEHAVIOUR
//  Reset (async, any state):
//   STATE=IDLE, CONTROL=0, GNT=0, VALID_OUT=0, SYM_CNT=0, DONE=0, ABORT=0, PTR=0.
//  States: IDLE, XFER (2-bit encoding, 3 unused -> IDLE).
//  IDLE:
//   - DONE/ABORT are low except for the single pulse cycle on entry.
//   - If REQ!=0: winner = first set bit scanning PTR, PTR+1, PTR+2 (mod 3).
//   - Next edge: GNT=onehot(winner), CONTROL=winner, SYM_CNT=0, VALID_OUT=1, ->XFER. Arbitration latency 1 cycle.
//   - REQ==0: stay; CONTROL holds its last value.
//  XFER:
//   - VALID_OUT=1, CONTROL and GNT stable for the whole burst.
//   - READY=0 stalls: SYM_CNT holds, no ACK.
//   - READY=1 and SYM_CNT<BURST_LEN-1: SYM_CNT+1.
//   - READY=1 and SYM_CNT==BURST_LEN-1: next edge ->IDLE, GNT=0, VALID_OUT=0, SYM_CNT=0, DONE=1, PTR=(winner+1) mod 3.
//   - REQ[winner]=0 sampled in XFER: takes precedence over READY, no SYM_ACK that cycle.
//     Next edge ->IDLE, ABORT=1, DONE=0, PTR=(winner+1) mod 3, GNT=0, VALID_OUT=0.
//   - REQ changes on non-granted bits are ignored until IDLE.
//  Gaps and arbitration:
//   - Minimum one IDLE cycle between bursts (DONE/ABORT cycle is that IDLE cycle; re-arbitration happens in it).
//   - Starvation-free: a held REQ is granted within 2 bursts.
//  Width rules:
//   - SYM_CNT compare uses 4-bit BURST_LEN-1.
//   - PTR is 2-bit mod-3, wraps 2->0, never 3.
//   - BURST_LEN=1: single-symbol bursts, DONE after first accept.
// TESTING
//  1 Reset mid-XFER (SYM_CNT=7) -> all outputs 0 same cycle async; after release IDLE, PTR=0.
//  2 REQ=3'b111 held, READY=1 -> grants source 0,1,2,0; each burst 15 ACKs;
//    DONE 16 cycles after GNT rises; CONTROL 0,1,2,0.
//  3 REQ=3'b010 only, READY toggling 1,0 -> burst takes 29 cycles;
//    SYM_CNT holds on READY=0; exactly 15 SYM_ACK[1] pulses; DONE once.
//  4 Source 0 in burst, REQ[0] drops at SYM_CNT=5 -> ABORT pulse, no DONE;
//    next grant goes to a pending source 1 (PTR=1), not source 0.
//  5 BURST_LEN=1, REQ=3'b101 -> alternating 1-symbol bursts: src0, src2, src0;
//    DONE every 2nd cycle, CONTROL never 3.
//  6 REQ=0 in IDLE for 20 cycles -> VALID_OUT, GNT, DONE stay 0; CONTROL unchanged.

Source files
------------

// File: rtl/mux_sched_rr3.sv
// Round-robin burst scheduler for the shared 3:1 symbol mux of the RS(15,11) decoder.
// The winning source holds the mux for one BURST_LEN-symbol burst; a dropped request aborts it.
module mux_sched_rr3 #(
    parameter int unsigned BURST_LEN = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       ready,
    output logic [1:0] control,
    output logic [2:0] gnt,
    output logic [2:0] sym_ack,
    output logic       valid_out,
    output logic [3:0] sym_cnt,
    output logic       done,
    output logic       abort
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       owner_req;

    // Mod-3 increment; the pointer and source indices never take the value 3.
    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : 2'(p + 2'd1);
    endfunction

    // Priority scan starting at the round-robin pointer.
    always_comb begin
        cand1 = inc3(ptr);
        cand2 = inc3(cand1);
        win   = cand2;
        if (req[ptr]) begin
            win = ptr;
        end else if (req[cand1]) begin
            win = cand1;
        end
    end

    assign owner_req = |(req & gnt);

    // A dropped owner request suppresses the acknowledge in the same cycle.
    always_comb begin
        sym_ack = 3'b000;
        if (state == XFER && owner_req && ready) begin
            sym_ack = gnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            control   <= 2'd0;
            gnt       <= 3'b000;
            valid_out <= 1'b0;
            sym_cnt   <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
            ptr       <= 2'd0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        state     <= XFER;
                        control   <= win;
                        gnt       <= 3'(3'b001 << win);
                        sym_cnt   <= '0;
                        valid_out <= 1'b1;
                    end
                end
                XFER: begin
                    if (!owner_req) begin
                        state     <= IDLE;
                        gnt       <= 3'b000;
                        valid_out <= 1'b0;
                        sym_cnt   <= '0;
                        abort     <= 1'b1;
                        ptr       <= inc3(control);
                    end else if (ready) begin
                        if (sym_cnt == LAST_SYM) begin
                            state     <= IDLE;
                            gnt       <= 3'b000;
                            valid_out <= 1'b0;
                            sym_cnt   <= '0;
                            done      <= 1'b1;
                            ptr       <= inc3(control);
                        end else begin
                            sym_cnt <= sym_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 3'b000;
                    valid_out <= 1'b0;
                    sym_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sched_rr3.sv
// Bench for mux_sched_rr3: a BURST_LEN=15 and a BURST_LEN=1 instance share the stimulus
// and are compared every cycle against a burst-level reference model.
module tb_mux_sched_rr3;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic       ready;

    logic [1:0] control_a, control_b;
    logic [2:0] gnt_a, gnt_b, sym_ack_a, sym_ack_b;
    logic       valid_a, valid_b, done_a, done_b, abort_a, abort_b;
    logic [3:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    // Model of each instance: who owns the mux, how far into its burst, and the pulses.
    int bl     [2] = '{15, 1};
    int m_busy [2];
    int m_src  [2];
    int m_ctrl [2];
    int m_ptr  [2];
    int m_cnt  [2];
    int m_done [2];
    int m_abort[2];
    int n_done  = 0;
    int n_abort = 0;

    mux_sched_rr3 #(.BURST_LEN(15)) dut_a (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .control(control_a), .gnt(gnt_a), .sym_ack(sym_ack_a), .valid_out(valid_a),
        .sym_cnt(cnt_a), .done(done_a), .abort(abort_a)
    );

    mux_sched_rr3 #(.BURST_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .ready(ready),
        .control(control_b), .gnt(gnt_b), .sym_ack(sym_ack_b), .valid_out(valid_b),
        .sym_cnt(cnt_b), .done(done_b), .abort(abort_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_src[i] = 0; m_ctrl[i] = 0; m_ptr[i] = 0;
            m_cnt[i] = 0; m_done[i] = 0; m_abort[i] = 0;
        end
    endtask

    // One clock edge of the scheduling rules, applied to the inputs seen before the edge.
    task automatic model_step(input logic [2:0] r, input logic rd);
        for (int i = 0; i < 2; i++) begin
            m_done[i]  = 0;
            m_abort[i] = 0;
            if (m_busy[i] == 0) begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (m_ptr[i] + k) % 3;
                    if (m_busy[i] == 0 && r[idx]) begin
                        m_busy[i] = 1; m_src[i] = idx; m_ctrl[i] = idx; m_cnt[i] = 0;
                    end
                end
            end else if (!r[m_src[i]]) begin
                m_busy[i] = 0; m_abort[i] = 1; m_cnt[i] = 0;
                m_ptr[i] = (m_src[i] + 1) % 3;
            end else if (rd) begin
                if (m_cnt[i] == bl[i] - 1) begin
                    m_busy[i] = 0; m_done[i] = 1; m_cnt[i] = 0;
                    m_ptr[i] = (m_src[i] + 1) % 3;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input string n, input logic [1:0] ctl,
                              input logic [2:0] g, input logic [2:0] ack, input logic v,
                              input logic [3:0] cnt, input logic d, input logic a);
        int eg, eack;
        eg   = m_busy[i] ? (1 << m_src[i]) : 0;
        eack = (m_busy[i] && req[m_src[i]] && ready) ? eg : 0;
        chk({n, ".control"}, int'(ctl), m_ctrl[i]);
        chk({n, ".gnt"}, int'(g), eg);
        chk({n, ".sym_ack"}, int'(ack), eack);
        chk({n, ".valid_out"}, int'(v), m_busy[i]);
        chk({n, ".sym_cnt"}, int'(cnt), m_cnt[i]);
        chk({n, ".done"}, int'(d), m_done[i]);
        chk({n, ".abort"}, int'(a), m_abort[i]);
        chk({n, ".control_not3"}, int'(ctl != 2'd3), 1);
    endtask

    // Entered and left at a falling edge: drive, check, then take one rising edge.
    task automatic tick(input logic [2:0] r, input logic rd);
        req   = r;
        ready = rd;
        #1;
        check_inst(0, "a", control_a, gnt_a, sym_ack_a, valid_a, cnt_a, done_a, abort_a);
        check_inst(1, "b", control_b, gnt_b, sym_ack_b, valid_b, cnt_b, done_b, abort_b);
        @(posedge clk);
        model_step(r, rd);
        n_done  += m_done[0];
        n_abort += m_abort[0];
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        int d0, a0;
        logic [2:0] r;
        reset = 1'b1;
        req   = 3'b000;
        ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no requests: nothing is granted and the select does not move.
        for (int c = 0; c < 20; c++) tick(3'b000, 1'b1);

        // All sources requesting continuously: strict rotation 0,1,2,0.
        d0 = n_done;
        for (int c = 0; c < 66; c++) tick(3'b111, 1'b1);
        chk("rr.done_count", n_done - d0, 4);

        // Single requester with a stalling sink.
        do_reset();
        d0 = n_done;
        for (int c = 0; c < 34; c++) tick(3'b010, 1'(c % 2 == 0));
        chk("stall.done_count", n_done - d0, 1);

        // Owner drops its request mid-burst; the pending source 1 wins next.
        do_reset();
        a0 = n_abort;
        d0 = n_done;
        guard = 0;
        tick(3'b011, 1'b1);
        while (m_cnt[0] != 5 && guard < 40) begin
            tick(3'b011, 1'b1);
            guard++;
        end
        chk("abort.reach_cnt5", m_cnt[0], 5);
        tick(3'b010, 1'b1);
        tick(3'b010, 1'b1);
        chk("abort.pulse_count", n_abort - a0, 1);
        chk("abort.no_done", n_done - d0, 0);
        chk("abort.next_gnt", int'(gnt_a), 2);

        // Asynchronous reset in the middle of a burst.
        guard = 0;
        while (!(m_busy[0] == 1 && m_cnt[0] == 7) && guard < 60) begin
            tick(3'b111, 1'b1);
            guard++;
        end
        chk("rst.reach_cnt7", int'(cnt_a), 7);
        #2 reset = 1'b1;
        #1;
        chk("rst.async_gnt", int'(gnt_a), 0);
        chk("rst.async_valid", int'(valid_a), 0);
        chk("rst.async_cnt", int'(cnt_a), 0);
        chk("rst.async_ctrl", int'(control_a), 0);
        chk("rst.async_ack", int'(sym_ack_a), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(3'b111, 1'b1);
        chk("rst.first_grant_src0", int'(gnt_a), 1);

        // Two-source traffic for the single-symbol instance: 0,2,0,...
        do_reset();
        for (int c = 0; c < 12; c++) tick(3'b101, 1'b1);

        // Random traffic with requests that mostly persist.
        r = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) r = 3'($urandom_range(7));
            tick(r, 1'($urandom_range(3) != 0));
        end

        req = 3'b000;
        #1;
        check_inst(0, "a", control_a, gnt_a, sym_ack_a, valid_a, cnt_a, done_a, abort_a);
        check_inst(1, "b", control_b, gnt_b, sym_ack_b, valid_b, cnt_b, done_b, abort_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
